// File: rtl/if_fetch_buf.sv
// Instruction-fetch stage: owns the fetch PC, issues single-outstanding imem requests,
// and buffers returned {pc, ins} pairs in a small FIFO for the register-fetch stage.
module if_fetch_buf #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned FIFO_DEPTH = 2,
    parameter logic [31:0] NOP_INS    = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_i,
    input  logic        pause,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_ack_i,
    input  logic [31:0] imem_data_i,
    output logic [31:0] ins_o,
    output logic [31:0] pc_o,
    output logic        ins_valid_o
);

    localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(FIFO_DEPTH);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(FIFO_DEPTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DROP = 2'd2
    } state_t;

    state_t           state;
    logic [31:0]      fpc;
    logic [31:0]      drop_addr;
    logic [31:0]      last_pc;
    logic [31:0]      redirect_fpc;
    logic [31:0]      pc_mem  [FIFO_DEPTH];
    logic [31:0]      ins_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] count_nxt;
    logic             push;
    logic             pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
    endfunction

    // Redirect wins over push/pop; the slot for a push was reserved when the request issued.
    always_comb begin
        redirect_fpc = redirect_pc_i & ~32'h0000_0003;
        push         = (state == REQ) && imem_ack_i && !redirect_i;
        pop          = (count != '0) && !pause && !redirect_i;
        count_nxt    = count + CNT_W'(push) - CNT_W'(pop);
    end

    always_comb begin
        imem_req_o  = (state == REQ) || (state == DROP);
        imem_addr_o = (state == DROP) ? drop_addr : fpc;
        ins_valid_o = (count != '0);
        ins_o       = ins_valid_o ? ins_mem[rd_ptr] : NOP_INS;
        pc_o        = ins_valid_o ? pc_mem[rd_ptr] : last_pc;
    end

    // Fetch control: DROP keeps the squashed address on the bus until its ack is swallowed.
    always_ff @(posedge clk or negedge rst_i) begin
        if (!rst_i) begin
            state     <= IDLE;
            fpc       <= RESET_PC;
            drop_addr <= RESET_PC;
        end else begin
            if (redirect_i) begin
                fpc <= redirect_fpc;
            end
            case (state)
                IDLE: begin
                    if (!redirect_i && (count < DEPTH_C)) begin
                        state <= REQ;
                    end
                end
                REQ: begin
                    if (redirect_i) begin
                        if (imem_ack_i) begin
                            state <= IDLE;
                        end else begin
                            state     <= DROP;
                            drop_addr <= fpc;
                        end
                    end else if (imem_ack_i) begin
                        fpc   <= fpc + 32'd4;
                        state <= (count_nxt < DEPTH_C) ? REQ : IDLE;
                    end
                end
                DROP: begin
                    if (imem_ack_i) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_i) begin
        if (!rst_i) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count   <= '0;
            last_pc <= 32'h0000_0000;
        end else begin
            last_pc <= pc_o;
            if (redirect_i) begin
                rd_ptr <= '0;
                wr_ptr <= '0;
                count  <= '0;
            end else begin
                if (push) begin
                    wr_ptr <= ptr_inc(wr_ptr);
                end
                if (pop) begin
                    rd_ptr <= ptr_inc(rd_ptr);
                end
                count <= count_nxt;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem[wr_ptr]  <= fpc;
            ins_mem[wr_ptr] <= imem_data_i;
        end
    end

endmodule
